// File: rtl/adc_lane_deser.sv
// Frame-aligned multi-lane ADC serial deserializer with lock tracking and slip statistics.
// Optional ramp checker on emitted words is built only when ADC_DESER_RAMP_CHECK_EN is defined.
module adc_lane_deser #(
    parameter int unsigned            LANES         = 1,
    parameter int unsigned            WORD_BITS     = 10,
    parameter logic [WORD_BITS-1:0]   FRAME_PATTERN = 10'h01F,
    parameter int unsigned            LOCK_COUNT    = 4,
    parameter int unsigned            UNLOCK_COUNT  = 3
) (
    input  logic                         ACLK,
    input  logic                         ARESETn,
    input  logic                         frame_bit,
    input  logic [LANES-1:0]             data_bits,
    output logic [LANES*WORD_BITS-1:0]   m_data,
    output logic                         m_valid,
    output logic                         locked,
    output logic                         lock_lost,
    output logic [7:0]                   slip_count,
    output logic [15:0]                  ramp_err_count
);

    localparam int unsigned CNT_W  = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned MISS_W = $clog2(UNLOCK_COUNT + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WORD_BITS - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);
    localparam logic [GOOD_W-1:0] GOOD_ONE  = GOOD_W'(1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(UNLOCK_COUNT - 1);
    localparam logic [MISS_W-1:0] MISS_ONE  = MISS_W'(1);

    typedef enum logic [1:0] {StSearch, StVerify, StLocked} state_e;

    state_e                            state_q, state_d;
    logic [WORD_BITS-1:0]              fsr_q;
    logic [LANES-1:0][WORD_BITS-1:0]   dsr_q;
    logic [CNT_W-1:0]                  cnt_q;
    logic [GOOD_W-1:0]                 good_q;
    logic [MISS_W-1:0]                 miss_q;
    logic [LANES*WORD_BITS-1:0]        m_data_q;
    logic                              m_valid_q;
    logic                              lock_lost_q;
    logic [7:0]                        slip_q;
    logic                              ever_locked_q;

    logic match;
    logic boundary;
    logic emit;
    logic enter_locked;
    logic enter_search;

    assign match        = (fsr_q == FRAME_PATTERN);
    assign boundary     = (state_q != StSearch) && (cnt_q == CNT_LAST);
    assign emit         = (state_q == StLocked) && boundary && match;
    assign enter_locked = (state_d == StLocked) && (state_q != StLocked);
    assign enter_search = (state_d == StSearch) && (state_q != StSearch);

    // State register
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q <= StSearch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StSearch: begin
                if (match) begin
                    state_d = (LOCK_COUNT == 1) ? StLocked : StVerify;
                end
            end
            StVerify: begin
                if (boundary) begin
                    if (!match) begin
                        state_d = StSearch;
                    end else if (good_q == GOOD_LAST) begin
                        state_d = StLocked;
                    end
                end
            end
            StLocked: begin
                if (boundary && !match && (miss_q == MISS_LAST)) begin
                    state_d = StSearch;
                end
            end
            default: state_d = StSearch;
        endcase
    end

    // Outputs
    always_comb begin
        locked     = (state_q == StLocked);
        m_data     = m_data_q;
        m_valid    = m_valid_q;
        lock_lost  = lock_lost_q;
        slip_count = slip_q;
    end

    // Shift registers, counters and output capture
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            fsr_q         <= '0;
            dsr_q         <= '0;
            cnt_q         <= '0;
            good_q        <= '0;
            miss_q        <= '0;
            m_data_q      <= '0;
            m_valid_q     <= 1'b0;
            lock_lost_q   <= 1'b0;
            slip_q        <= '0;
            ever_locked_q <= 1'b0;
        end else begin
            fsr_q <= {frame_bit, fsr_q[WORD_BITS-1:1]};
            for (int i = 0; i < int'(LANES); i++) begin
                dsr_q[i] <= {data_bits[i], dsr_q[i][WORD_BITS-1:1]};
            end

            // The match cycle in SEARCH defines the word phase; cnt restarts from it.
            if ((state_q == StSearch) && match) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_ONE;
            end

            if ((state_q == StSearch) && match) begin
                good_q <= GOOD_ONE;
            end else if ((state_q == StVerify) && boundary && match) begin
                good_q <= good_q + GOOD_ONE;
            end

            if (enter_locked) begin
                miss_q <= '0;
            end else if ((state_q == StLocked) && boundary) begin
                miss_q <= match ? '0 : miss_q + MISS_ONE;
            end

            m_valid_q <= emit;
            if (emit) begin
                m_data_q <= dsr_q;
            end

            lock_lost_q <= (state_q == StLocked) && (state_d == StSearch);

            if (enter_search && ever_locked_q && (slip_q != 8'hFF)) begin
                slip_q <= slip_q + 8'd1;
            end

            if (enter_locked) begin
                ever_locked_q <= 1'b1;
            end
        end
    end

`ifdef ADC_DESER_RAMP_CHECK_EN
    localparam logic [WORD_BITS-1:0] WORD_ONE = WORD_BITS'(1);

    logic [LANES-1:0][WORD_BITS-1:0] ramp_ref_q;
    logic                            ramp_seeded_q;
    logic [15:0]                     ramp_err_q;
    logic [16:0]                     ramp_errs;
    logic [16:0]                     ramp_sum;

    always_comb begin
        ramp_errs = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            if (dsr_q[i] != (ramp_ref_q[i] + WORD_ONE)) begin
                ramp_errs = ramp_errs + 17'd1;
            end
        end
        ramp_sum = {1'b0, ramp_err_q} + ramp_errs;
    end

    // First word after entering LOCKED only seeds the reference.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            ramp_ref_q    <= '0;
            ramp_seeded_q <= 1'b0;
            ramp_err_q    <= '0;
        end else if (state_q != StLocked) begin
            ramp_seeded_q <= 1'b0;
        end else if (emit) begin
            if (ramp_seeded_q) begin
                ramp_err_q <= ramp_sum[16] ? 16'hFFFF : ramp_sum[15:0];
            end
            ramp_ref_q    <= dsr_q;
            ramp_seeded_q <= 1'b1;
        end
    end

    assign ramp_err_count = ramp_err_q;
`else
    assign ramp_err_count = '0;
`endif

endmodule

// File: tb/tb_adc_lane_deser.sv
// Directed bench for adc_lane_deser with two lanes: lock, phase, glitch, slip, reset, ramp.
module tb_adc_lane_deser;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        frame_bit = 1'b0;
    logic [1:0]  data_bits = '0;
    logic [19:0] m_data;
    logic        m_valid;
    logic        locked;
    logic        lock_lost;
    logic [7:0]  slip_count;
    logic [15:0] ramp_err_count;

    int n_vec = 0;
    int n_bad = 0;

    adc_lane_deser #(
        .LANES(2),
        .WORD_BITS(10),
        .FRAME_PATTERN(10'h01F),
        .LOCK_COUNT(4),
        .UNLOCK_COUNT(3)
    ) dut (
        .ACLK(ACLK),
        .ARESETn(ARESETn),
        .frame_bit(frame_bit),
        .data_bits(data_bits),
        .m_data(m_data),
        .m_valid(m_valid),
        .locked(locked),
        .lock_lost(lock_lost),
        .slip_count(slip_count),
        .ramp_err_count(ramp_err_count)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    // Monitor: strobes, lock rise and lock_lost pulses seen at the falling edge
    logic [19:0] q_data[$];
    int          q_cyc[$];
    int          lock_rise_cyc = -1;
    int          lost_cnt = 0;
    int          lost_cyc = -1;
    logic        locked_prev = 1'b0;
    int          t0 = 0;

    always @(negedge ACLK) begin
        if (m_valid === 1'b1) begin
            q_data.push_back(m_data);
            q_cyc.push_back(cyc);
        end
        if (locked === 1'b1 && locked_prev !== 1'b1) lock_rise_cyc = cyc;
        locked_prev = locked;
        if (lock_lost === 1'b1) begin
            lost_cnt++;
            lost_cyc = cyc;
        end
    end

    task automatic clear_mon();
        q_data.delete();
        q_cyc.delete();
        lock_rise_cyc = -1;
        lost_cnt = 0;
        lost_cyc = -1;
    endtask

    task automatic do_reset();
        ARESETn = 1'b0;
        frame_bit = 1'b0;
        data_bits = '0;
        @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        t0 = cyc;
        clear_mon();
    endtask

    task automatic send_bits(input logic [9:0] fr, input logic [9:0] d0, input logic [9:0] d1,
                             input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            frame_bit = fr[k];
            data_bits = {d1[k], d0[k]};
            @(posedge ACLK);
            #1;
        end
    endtask

    task automatic send_word(input logic [9:0] fr, input logic [9:0] d0, input logic [9:0] d1);
        send_bits(fr, d0, d1, 0, 9);
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        frame_bit = 1'b1;
        data_bits = 2'b11;
        @(posedge ACLK);
        #1;
        n_vec++; if (m_data !== 20'h0) begin n_bad++; $display("FAIL reset_m_data got %h want 0", m_data); end
        n_vec++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
        n_vec++; if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked got %b want 0", locked); end
        n_vec++; if (lock_lost !== 1'b0) begin n_bad++; $display("FAIL reset_lock_lost got %b want 0", lock_lost); end
        n_vec++; if (slip_count !== 8'h0) begin n_bad++; $display("FAIL reset_slip got %0d want 0", slip_count); end
        n_vec++; if (ramp_err_count !== 16'h0) begin n_bad++; $display("FAIL reset_ramp got %0d want 0", ramp_err_count); end
    endtask

    task automatic test_lock_acquire();
        logic [9:0] w;
        logic [19:0] exp_d;
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            w = 10'(i);
            send_word(10'h01F, w, w + 10'h100);
        end
        n_vec++; if (lock_rise_cyc !== t0 + 41) begin n_bad++; $display("FAIL acq_lock_cyc got %0d want %0d", lock_rise_cyc - t0, 41); end
        n_vec++; if (q_data.size() !== 4) begin n_bad++; $display("FAIL acq_strobes got %0d want 4", q_data.size()); end
        for (int i = 0; i < 4 && i < q_data.size(); i++) begin
            w = 10'(5 + i);
            exp_d = {w + 10'h100, w};
            n_vec++; if (q_data[i] !== exp_d) begin n_bad++; $display("FAIL acq_data[%0d] got %h want %h", i, q_data[i], exp_d); end
            n_vec++; if (q_cyc[i] !== t0 + 51 + 10 * i) begin n_bad++; $display("FAIL acq_cyc[%0d] got %0d want %0d", i, q_cyc[i] - t0, 51 + 10 * i); end
        end
        n_vec++; if (locked !== 1'b1) begin n_bad++; $display("FAIL acq_locked got %b want 1", locked); end
    endtask

    task automatic test_no_pattern();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            send_word((i < 3) ? 10'h000 : 10'h3FF, 10'h155, 10'h2AA);
        end
        n_vec++; if (locked !== 1'b0) begin n_bad++; $display("FAIL nopat_locked got %b want 0", locked); end
        n_vec++; if (q_data.size() !== 0) begin n_bad++; $display("FAIL nopat_strobes got %0d want 0", q_data.size()); end
    endtask

    task automatic test_phase();
        logic [9:0] w;
        do_reset();
        send_bits(10'h01F, 10'h001, 10'h101, 3, 9);
        for (int i = 2; i <= 10; i++) begin
            w = 10'(i);
            send_word(10'h01F, w, w + 10'h100);
        end
        n_vec++; if (lock_rise_cyc !== t0 + 48) begin n_bad++; $display("FAIL phase_lock_cyc got %0d want 48", lock_rise_cyc - t0); end
        n_vec++; if (q_data.size() !== 4) begin n_bad++; $display("FAIL phase_strobes got %0d want 4", q_data.size()); end
        if (q_data.size() > 0) begin
            n_vec++; if (q_data[0] !== {10'h106, 10'h006}) begin n_bad++; $display("FAIL phase_first got %h want %h", q_data[0], {10'h106, 10'h006}); end
            n_vec++; if (q_cyc[0] !== t0 + 58) begin n_bad++; $display("FAIL phase_first_cyc got %0d want 58", q_cyc[0] - t0); end
        end
    endtask

    task automatic test_glitch();
        logic [9:0] w;
        logic [9:0] fr;
        int exp_list[7];
        exp_list = '{5, 6, 8, 9, 10, 12, 14};
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            w = 10'(i);
            fr = (i == 7 || i == 11 || i == 13 || i == 15) ? 10'h03F : 10'h01F;
            send_word(fr, w, w + 10'h100);
        end
        n_vec++; if (q_data.size() !== 7) begin n_bad++; $display("FAIL glitch_strobes got %0d want 7", q_data.size()); end
        for (int i = 0; i < 7 && i < q_data.size(); i++) begin
            w = 10'(exp_list[i]);
            n_vec++; if (q_data[i] !== {w + 10'h100, w}) begin n_bad++; $display("FAIL glitch_data[%0d] got %h want %h", i, q_data[i], {w + 10'h100, w}); end
        end
        n_vec++; if (locked !== 1'b1) begin n_bad++; $display("FAIL glitch_locked got %b want 1", locked); end
        n_vec++; if (lost_cnt !== 0) begin n_bad++; $display("FAIL glitch_lost got %0d want 0", lost_cnt); end
        n_vec++; if (slip_count !== 8'd0) begin n_bad++; $display("FAIL glitch_slip got %0d want 0", slip_count); end
    endtask

    task automatic test_slip();
        logic [9:0] w;
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            w = 10'(i);
            send_word(10'h01F, w, w + 10'h100);
        end
        send_bits(10'h000, 10'h000, 10'h000, 0, 3);
        for (int i = 7; i <= 14; i++) begin
            w = 10'(i);
            send_word(10'h01F, w, w + 10'h100);
        end
        n_vec++; if (lost_cnt !== 1) begin n_bad++; $display("FAIL slip_lost_pulses got %0d want 1", lost_cnt); end
        n_vec++; if (lost_cyc !== t0 + 91) begin n_bad++; $display("FAIL slip_lost_cyc got %0d want 91", lost_cyc - t0); end
        n_vec++; if (slip_count !== 8'd1) begin n_bad++; $display("FAIL slip_count got %0d want 1", slip_count); end
        n_vec++; if (lock_rise_cyc !== t0 + 125) begin n_bad++; $display("FAIL slip_relock_cyc got %0d want 125", lock_rise_cyc - t0); end
        n_vec++; if (q_data.size() !== 3) begin n_bad++; $display("FAIL slip_strobes got %0d want 3", q_data.size()); end
        if (q_data.size() > 2) begin
            n_vec++; if (q_data[2] !== {10'h10D, 10'h00D}) begin n_bad++; $display("FAIL slip_data got %h want %h", q_data[2], {10'h10D, 10'h00D}); end
            n_vec++; if (q_cyc[2] !== t0 + 135) begin n_bad++; $display("FAIL slip_data_cyc got %0d want 135", q_cyc[2] - t0); end
        end
        n_vec++; if (locked !== 1'b1) begin n_bad++; $display("FAIL slip_locked got %b want 1", locked); end
    endtask

    task automatic test_reset_midword();
        do_reset();
        for (int i = 1; i <= 6; i++) send_word(10'h01F, 10'h155, 10'h2AA);
        send_bits(10'h01F, 10'h155, 10'h2AA, 0, 5);
        n_vec++; if (q_data.size() !== 2) begin n_bad++; $display("FAIL midrst_pre_strobes got %0d want 2", q_data.size()); end
        ARESETn = 1'b0;
        frame_bit = 1'b0;
        data_bits = {1'b0, 1'b1};
        @(posedge ACLK);
        #1;
        n_vec++; if (m_data !== 20'h0) begin n_bad++; $display("FAIL midrst_m_data got %h want 0", m_data); end
        n_vec++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_m_valid got %b want 0", m_valid); end
        n_vec++; if (locked !== 1'b0) begin n_bad++; $display("FAIL midrst_locked got %b want 0", locked); end
        n_vec++; if (slip_count !== 8'd0) begin n_bad++; $display("FAIL midrst_slip got %0d want 0", slip_count); end
        ARESETn = 1'b1;
        t0 = cyc;
        clear_mon();
        for (int i = 1; i <= 6; i++) send_word(10'h01F, 10'h155, 10'h2AA);
        n_vec++; if (lock_rise_cyc !== t0 + 41) begin n_bad++; $display("FAIL midrst_lock_cyc got %0d want 41", lock_rise_cyc - t0); end
        n_vec++; if (q_data.size() !== 1) begin n_bad++; $display("FAIL midrst_strobes got %0d want 1", q_data.size()); end
        if (q_data.size() > 0) begin
            n_vec++; if (q_data[0] !== {10'h2AA, 10'h155}) begin n_bad++; $display("FAIL midrst_data got %h want %h", q_data[0], {10'h2AA, 10'h155}); end
        end
    endtask

    task automatic test_ramp();
        logic [9:0] ramp0[5];
        logic [15:0] exp_ramp;
        ramp0 = '{10'h3FE, 10'h3FF, 10'h000, 10'h005, 10'h006};
`ifdef ADC_DESER_RAMP_CHECK_EN
        exp_ramp = 16'd1;
`else
        exp_ramp = 16'd0;
`endif
        do_reset();
        for (int i = 0; i < 4; i++) send_word(10'h01F, 10'h000, 10'h000);
        for (int i = 0; i < 4; i++) send_word(10'h01F, ramp0[i], 10'(10'h100 + i));
        n_vec++; if (ramp_err_count !== 16'd0) begin n_bad++; $display("FAIL ramp_wrap got %0d want 0", ramp_err_count); end
        send_word(10'h01F, ramp0[4], 10'h104);
        n_vec++; if (ramp_err_count !== exp_ramp) begin n_bad++; $display("FAIL ramp_jump got %0d want %0d", ramp_err_count, exp_ramp); end
        n_vec++; if (q_data.size() !== 4) begin n_bad++; $display("FAIL ramp_strobes got %0d want 4", q_data.size()); end
        if (q_data.size() > 3) begin
            n_vec++; if (q_data[3] !== {10'h103, 10'h005}) begin n_bad++; $display("FAIL ramp_data got %h want %h", q_data[3], {10'h103, 10'h005}); end
        end
    endtask

    initial begin
        test_reset();
        test_lock_acquire();
        test_no_pattern();
        test_phase();
        test_glitch();
        test_slip();
        test_reset_midword();
        test_ramp();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/adc_lane_deser.md
Name: adc_lane_deser

Overview:
- Receive-side counterpart of the ADC serial-lane stimulus. Consumes one sampled bit per clock per data lane plus one frame-clock bit.
- Aligns to the 10-bit frame pattern, deserializes LSB-first words, and emits parallel sample words with a valid strobe.
- Sits between the LVDS input buffers/IDDR sampling and the windowing/FFT input path.
- Reports lock status and slip statistics to the register block.

Parameters:
- LANES, 1, number of serial data lanes deserialized in parallel
- WORD_BITS, 10, bits per sample word and per frame period
- FRAME_PATTERN, 10'h01F, expected frame-bit word, LSB = first bit received
- LOCK_COUNT, 4, consecutive matching frames (including the detection frame) required to declare lock
- UNLOCK_COUNT, 3, consecutive mismatching frames in LOCKED that force re-search

Ports:
- ACLK  in  1  bit-rate sampling clock; all logic on rising edge
- ARESETn  in  1  reset, synchronous, active-low
- frame_bit  in  1  sampled frame-clock bit, one per ACLK
- data_bits  in  LANES  sampled data bit per lane, one per ACLK
- m_data  out  LANES*WORD_BITS  lane i at [WORD_BITS*i+WORD_BITS-1 : WORD_BITS*i]; word bit k = k-th bit received
- m_valid  out  1  one-cycle strobe, m_data valid
- locked  out  1  high in LOCKED state
- lock_lost  out  1  one-cycle pulse on LOCKED->SEARCH
- slip_count  out  8  count of entries into SEARCH after the first lock, saturating at 255
- ramp_err_count  out  16  ramp-check errors (see Optional Feature)

Behaviour:
- Shift registers, every cycle:
  - fsr <= {frame_bit, fsr[WORD_BITS-1:1]}
  - per lane, dsr_i <= {data_bits[i], dsr_i[WORD_BITS-1:1]}
  - After WORD_BITS shifts, element 0 holds the first-arrived bit.
- Bit counter cnt, 0..WORD_BITS-1. A "boundary" is a cycle with cnt == WORD_BITS-1 in VERIFY or LOCKED. At a boundary cnt wraps to 0; otherwise it increments.
- FSM states: SEARCH, VERIFY, LOCKED.
- SEARCH:
  - Each cycle compare fsr with FRAME_PATTERN.
  - On match: cnt <= 0, good <= 1, go to VERIFY. If LOCK_COUNT == 1, go directly to LOCKED.
- VERIFY:
  - At a boundary with match: good++. When good reaches LOCK_COUNT, go to LOCKED with miss <= 0.
  - At a boundary with mismatch: go to SEARCH.
  - No output is produced in VERIFY.
- LOCKED:
  - At a boundary with match: m_data <= dsr (all lanes), m_valid <= 1 next cycle, miss <= 0.
  - At a boundary with mismatch: no output, miss++. When miss reaches UNLOCK_COUNT: go to SEARCH, lock_lost pulses 1 cycle, slip_count++ (saturating).
- Latency: m_valid rises 1 ACLK after the edge that shifts in the word's last bit. m_valid is never high on two consecutive cycles.
- Re-search timing: SEARCH evaluates fsr starting the cycle after entry, so a realigned pattern is found within WORD_BITS cycles.
- Reset (ARESETn low at a rising edge):
  - State SEARCH; fsr, dsr, cnt, good, miss = 0.
  - m_data = 0, m_valid = 0, locked = 0, lock_lost = 0, slip_count = 0, ramp_err_count = 0.
  - Reset mid-word discards the partial word; nothing is emitted.
- All-zero or all-one frame input never matches, so the block stays in SEARCH with no outputs.

Optional Feature:
- Macro: ADC_DESER_RAMP_CHECK_EN.
- With the macro defined:
  - In LOCKED, each emitted lane word is compared with (previous word of that lane + 1) mod 2^WORD_BITS.
  - The first word after entering LOCKED only seeds the reference.
  - Each mismatching lane increments ramp_err_count by 1, saturating at 16'hFFFF. The reference always updates to the received word.
- Without the macro: no checker logic is built and ramp_err_count is tied to 0.

Test Plan:
- Lock acquisition:
  - Stimulus: LANES=1, frame 0x01F, data words 0x001, 0x002, ... serialized LSB-first from cycle 0 after reset.
  - Required: locked rises at the end of frame 4; first m_valid carries 0x005; one strobe every 10 cycles; each m_data equals the sent word.
- Arbitrary phase:
  - Stimulus: start the stream 3 bits into a frame.
  - Required: the partial frame is ignored; the first complete frame is detected; the first output is the 5th complete word.
- Single glitch while locked:
  - Stimulus: corrupt one frame to 0x03F.
  - Required: that word is not emitted; locked stays 1; miss resets on the next match; slip_count stays 0.
- Loss of lock:
  - Stimulus: insert a 4-bit slip in the frame stream.
  - Required: after 3 mismatching frames lock_lost pulses once, locked falls, slip_count = 1; relock completes 4 frames after the new alignment is found; data is correct at the new phase.
- Reset mid-word, LANES=2:
  - Stimulus: lanes sending 0x155 and 0x2AA; assert ARESETn low for 1 cycle at bit 6 of a word.
  - Required: all outputs 0 next cycle; relock with lane0 = 0x155 and lane1 = 0x2AA.
- Ramp check (ADC_DESER_RAMP_CHECK_EN):
  - Stimulus: ramp 0x3FE, 0x3FF, 0x000, 0x005.
  - Required: wrap from 0x3FF to 0x000 causes no error; 0x005 gives ramp_err_count = 1.
  - Without the macro, ramp_err_count stays 0.
